mul_fu: RTL and testbench
=========================

// Module: mul_fu
// PURPOSE
// Pipelined integer multiply functional unit, downstream of the reservation station's issue port.
// Accepts one issued RV32M multiply per cycle: MUL, MULH, MULHSU, MULHU.
// Carries the op through STAGES register stages and broadcasts the result on the completion bus.
// A separate completion arbiter grants the bus. In-flight ops younger than a rewind point are squashed.
// PARAMETERS
// STAGES  3   pipeline depth; cycles from issue acceptance to cpl_valid, no stall (>=2)
// XLEN    32  operand/result width
// PHY_W   6   physical register index width
// ROB_W   5   ROB index width; ROB depth = 2**ROB_W
// PORTS
// clock           in   1      rising-edge clock
// reset           in   1      synchronous, active-high
// issue_valid     in   1      RS presents a multiply this cycle
// issue_fun       in   3      [1:0]: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU; bit 2 ignored
// issue_rs1       in   XLEN   operand A value
// issue_rs2       in   XLEN   operand B value
// issue_dst       in   PHY_W  destination physical register
// issue_rob_idx   in   ROB_W  ROB index of the op
// issue_avail     out  1      unit accepts an op this cycle
// cpl_valid       out  1      result request to completion arbiter
// cpl_value       out  XLEN   result
// cpl_dst         out  PHY_W  destination physical register of result
// cpl_rob_idx     out  ROB_W  ROB index of result
// cpl_grant       in   1      arbiter grants bus; meaningful only while cpl_valid
// rewind_valid    in   1      squash request this cycle
// rewind_rob_idx  in   ROB_W  oldest ROB index to squash
// rob_head        in   ROB_W  current ROB head (oldest op), for age compare
// BEHAVIOUR
// - State: STAGES slots s[0..STAGES-1], each {valid, fun, partial product/operands, dst, rob_idx}.
// - Reset: all slot valid bits cleared. While reset=1: issue_avail=0, cpl_valid=0.
// - Outputs when cpl_valid=0: cpl_value, cpl_dst, cpl_rob_idx driven 0.
// - Handshake: op accepted when issue_valid && issue_avail. RS must drop the op only on accept.
// - Advance, last slot: adv[N-1] = !s[N-1].valid || cpl_grant.
// - Advance, other slots: adv[k] = !s[k].valid || !s[k+1].valid || adv[k+1].
// - A slot that does not advance holds its contents. No bubble is ever inserted ahead of a held op.
// - issue_avail = adv[0] && !rewind_valid && !reset. This path is combinational, including from cpl_grant.
// - Latency: op accepted in cycle t shows cpl_valid in cycle t+STAGES if granted every cycle.
// - Throughput: 1 op/cycle with continuous grant.
// - Stall: cpl_valid and all cpl_* stay stable until cpl_grant, unless squashed.
// - Arithmetic: A and B are each extended to XLEN+1 bits.
//   - A is sign-extended for fun 1 and 2, zero-extended otherwise.
//   - B is sign-extended for fun 1 only, zero-extended otherwise.
//   - The 2*XLEN+2-bit signed product P is formed.
//   - MUL returns P[XLEN-1:0]; all other functions return P[2*XLEN-1:XLEN].
//   - The partial-product split across stages is free; only the final value is checked.
// - Rewind: age(x) = (x - rob_head) mod 2**ROB_W.
//   - While rewind_valid, every valid slot with age(rob_idx) >= age(rewind_rob_idx) is squashed.
//   - A squashed slot is invalid from the next edge.
//   - In the rewind cycle, cpl_valid is masked combinationally if the last slot is squashed.
//   - Older slots are unaffected and keep advancing normally in the rewind cycle.
//   - A squashed last slot counts as free for adv[] in the same cycle.
// - Simultaneous: cpl_grant to a slot being squashed is a don't-care; the result is never broadcast.
// - Reset mid-operation: all in-flight ops are lost and no completion is emitted.
// TESTING
// - Single MUL: issue_rs1=7, issue_rs2=6, dst=5, rob=3, accepted cycle 10, grant=1.
//   -> cycle 13: cpl_valid=1, value=42, dst=5, rob=3; exactly one pulse.
// - MULH/MULHSU/MULHU with rs1=0xFFFFFFFF, rs2=0x00000002, grant=1.
//   -> 0xFFFFFFFF, 0xFFFFFFFF, 0x00000001 respectively.
//   -> MUL of 0x80000000 x 0x80000000 gives 0x00000000.
// - Back-pressure: issue 4 back-to-back ops, hold cpl_grant=0.
//   -> issue_avail drops after 3 accepts; cpl outputs stay stable.
//   -> after grant=1 for 3 cycles, all 3 accepted ops complete in order; the 4th is then accepted.
// - Rewind: rob_head=30, three in-flight ops rob 30, 31, 0; rewind_rob_idx=31 for one cycle.
//   -> only rob 30 completes; issue_avail=0 during the rewind cycle.
// - Rewind of last slot while cpl_valid=1 and cpl_grant=1.
//   -> cpl_valid=0 that cycle; the squashed op is never seen on the completion bus.
// - Reset asserted with 3 ops in flight.
//   -> cpl_valid=0 during and after reset; issue_avail=1 the first cycle after reset deasserts.

Source files
------------

// File: rtl/mul_fu.sv
// rtl/mul_fu.sv - pipelined RV32M multiply unit with completion back-pressure and rewind squash
//
// Purpose: accepts one issued MUL/MULH/MULHSU/MULHU per cycle, carries it through
// STAGES slots and requests the completion bus from the last slot. Ops whose ROB age
// is at or beyond the rewind point are squashed in flight.
//
// Ports:
//   clock_i, reset_i        rising-edge clock, synchronous active-high reset
//   issue_*_i / issue_avail_o  issue handshake from the reservation station
//   cpl_*_o / cpl_grant_i      completion request/result and arbiter grant
//   rewind_valid_i, rewind_rob_idx_i, rob_head_i  squash request and age reference
module mul_fu #(
   parameter int STAGES = 3,
   parameter int XLEN   = 32,
   parameter int PHY_W  = 6,
   parameter int ROB_W  = 5
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             issue_valid_i,
   input  logic [2:0]       issue_fun_i,
   input  logic [XLEN-1:0]  issue_rs1_i,
   input  logic [XLEN-1:0]  issue_rs2_i,
   input  logic [PHY_W-1:0] issue_dst_i,
   input  logic [ROB_W-1:0] issue_rob_idx_i,
   output logic             issue_avail_o,
   output logic             cpl_valid_o,
   output logic [XLEN-1:0]  cpl_value_o,
   output logic [PHY_W-1:0] cpl_dst_o,
   output logic [ROB_W-1:0] cpl_rob_idx_o,
   input  logic             cpl_grant_i,
   input  logic             rewind_valid_i,
   input  logic [ROB_W-1:0] rewind_rob_idx_i,
   input  logic [ROB_W-1:0] rob_head_i
);

   logic [STAGES-1:0] valid_q, valid_d;
   logic [XLEN-1:0]   value_q [STAGES];
   logic [XLEN-1:0]   value_d [STAGES];
   logic [PHY_W-1:0]  dst_q   [STAGES];
   logic [PHY_W-1:0]  dst_d   [STAGES];
   logic [ROB_W-1:0]  rob_q   [STAGES];
   logic [ROB_W-1:0]  rob_d   [STAGES];

   logic [STAGES-1:0] squash, live, adv;
   logic [ROB_W-1:0]  rw_age, slot_age;
   logic              avail, accept;

   // Only the low two function bits select the operation.
   logic [1:0] fun_sel;
   logic       unused_fun_hi;
   assign fun_sel       = issue_fun_i[1:0];
   assign unused_fun_hi = issue_fun_i[2];

   // Operands extended to 2*XLEN; the low 2*XLEN bits of the product equal the
   // low bits of the XLEN+1 signed product for every sign combination.
   logic              a_sx, b_sx;
   logic [2*XLEN-1:0] a_w, b_w, prod_w;
   logic [XLEN-1:0]   mul_result;
   assign a_sx       = issue_rs1_i[XLEN-1] & ((fun_sel == 2'd1) | (fun_sel == 2'd2));
   assign b_sx       = issue_rs2_i[XLEN-1] & (fun_sel == 2'd1);
   assign a_w        = {{XLEN{a_sx}}, issue_rs1_i};
   assign b_w        = {{XLEN{b_sx}}, issue_rs2_i};
   assign prod_w     = a_w * b_w;
   assign mul_result = (fun_sel == 2'd0) ? prod_w[XLEN-1:0] : prod_w[2*XLEN-1:XLEN];

   always_comb begin
      squash   = '0;
      live     = '0;
      adv      = '0;
      slot_age = '0;
      rw_age   = rewind_rob_idx_i - rob_head_i;
      for (int k = 0; k < STAGES; k++) begin
         slot_age  = rob_q[k] - rob_head_i;
         squash[k] = rewind_valid_i && valid_q[k] && (slot_age >= rw_age);
         live[k]   = valid_q[k] && !squash[k];
      end

      // A squashed slot is treated as empty so the chain sees it as free this cycle.
      adv[STAGES-1] = !live[STAGES-1] || cpl_grant_i;
      for (int k = STAGES - 2; k >= 0; k--) begin
         adv[k] = !live[k] || !live[k+1] || adv[k+1];
      end

      avail         = adv[0] && !rewind_valid_i && !reset_i;
      accept        = issue_valid_i && avail;
      issue_avail_o = avail;

      for (int k = 0; k < STAGES; k++) begin
         valid_d[k] = live[k];
         value_d[k] = value_q[k];
         dst_d[k]   = dst_q[k];
         rob_d[k]   = rob_q[k];
      end

      if (adv[0]) begin
         valid_d[0] = accept;
         value_d[0] = mul_result;
         dst_d[0]   = issue_dst_i;
         rob_d[0]   = issue_rob_idx_i;
      end

      for (int k = 1; k < STAGES; k++) begin
         if (adv[k]) begin
            valid_d[k] = live[k-1];
            value_d[k] = value_q[k-1];
            dst_d[k]   = dst_q[k-1];
            rob_d[k]   = rob_q[k-1];
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
      value_q <= value_d;
      dst_q   <= dst_d;
      rob_q   <= rob_d;
   end

   // Squash masks the request in the same cycle; reset masks a slot still marked valid.
   assign cpl_valid_o   = live[STAGES-1] && !reset_i;
   assign cpl_value_o   = cpl_valid_o ? value_q[STAGES-1] : '0;
   assign cpl_dst_o     = cpl_valid_o ? dst_q[STAGES-1]   : '0;
   assign cpl_rob_idx_o = cpl_valid_o ? rob_q[STAGES-1]   : '0;

endmodule

// File: tb/tb_mul_fu.sv
// tb/tb_mul_fu.sv - self-checking bench for mul_fu: vector table, corner sequences, random vs reference queue
module tb_mul_fu;
   localparam int STAGES = 3;
   localparam int XLEN   = 32;
   localparam int PHY_W  = 6;
   localparam int ROB_W  = 5;

   logic             clk;
   logic             reset;
   logic             issue_valid;
   logic [2:0]       issue_fun;
   logic [XLEN-1:0]  issue_rs1, issue_rs2;
   logic [PHY_W-1:0] issue_dst;
   logic [ROB_W-1:0] issue_rob_idx;
   logic             issue_avail;
   logic             cpl_valid;
   logic [XLEN-1:0]  cpl_value;
   logic [PHY_W-1:0] cpl_dst;
   logic [ROB_W-1:0] cpl_rob_idx;
   logic             cpl_grant;
   logic             rewind_valid;
   logic [ROB_W-1:0] rewind_rob_idx;
   logic [ROB_W-1:0] rob_head;

   mul_fu #(.STAGES(STAGES), .XLEN(XLEN), .PHY_W(PHY_W), .ROB_W(ROB_W)) dut (
      .clock_i(clk), .reset_i(reset),
      .issue_valid_i(issue_valid), .issue_fun_i(issue_fun),
      .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
      .issue_dst_i(issue_dst), .issue_rob_idx_i(issue_rob_idx),
      .issue_avail_o(issue_avail),
      .cpl_valid_o(cpl_valid), .cpl_value_o(cpl_value),
      .cpl_dst_o(cpl_dst), .cpl_rob_idx_o(cpl_rob_idx),
      .cpl_grant_i(cpl_grant),
      .rewind_valid_i(rewind_valid), .rewind_rob_idx_i(rewind_rob_idx),
      .rob_head_i(rob_head)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [XLEN-1:0]  val;
      logic [PHY_W-1:0] dst;
      logic [ROB_W-1:0] rob;
      int               t;
   } ent_t;

   typedef struct {
      logic [2:0]      fun;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] exp_v;
   } vec_t;

   ent_t             q[$];
   int               cyc;
   int               nerr;
   int               nchk;
   int               dut_cpl;
   int               dut_acc;
   logic [XLEN-1:0]  drv_exp;
   logic [ROB_W-1:0] next_rob;
   bit               last_acc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      nchk++;
      if (act !== exp_v) begin
         nerr++;
         $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp_v);
      end
   endtask

   task automatic timeout(input string nm);
      nchk++;
      nerr++;
      $display("FAIL %s cyc=%0d: bound expired", nm, cyc);
   endtask

   // Reference product from the arithmetic rules: extend each operand by its
   // signedness, multiply as 64-bit integers, pick the low or high word.
   function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      longint sa, sb, p;
      logic [1:0] op;
      op = f[1:0];
      sa = (op == 2'd1 || op == 2'd2) ? longint'($signed(x)) : longint'({32'b0, x});
      sb = (op == 2'd1) ? longint'($signed(y)) : longint'({32'b0, y});
      p  = sa * sb;
      return (op == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   function automatic int age(input logic [ROB_W-1:0] x);
      logic [ROB_W-1:0] d;
      d = x - rob_head;
      return int'(d);
   endfunction

   // Called at the falling edge: inputs for this cycle are stable.
   task automatic check_cycle();
      bit   ev, ea;
      ent_t e;
      if (cpl_valid && cpl_grant) dut_cpl++;
      if (issue_valid && issue_avail) dut_acc++;
      if (rewind_valid && !reset) begin
         while (q.size() > 0 && age(q[q.size()-1].rob) >= age(rewind_rob_idx)) q.pop_back();
      end
      ev = !reset && q.size() > 0 && (cyc >= q[0].t + STAGES);
      ea = !reset && !rewind_valid && (q.size() < STAGES || (ev && cpl_grant));
      chk("cpl_valid", cpl_valid, ev);
      if (ev) begin
         chk("cpl_value", cpl_value, q[0].val);
         chk("cpl_dst", cpl_dst, q[0].dst);
         chk("cpl_rob_idx", cpl_rob_idx, q[0].rob);
      end else begin
         chk("idle_value", cpl_value, 0);
         chk("idle_dst", cpl_dst, 0);
         chk("idle_rob", cpl_rob_idx, 0);
      end
      chk("issue_avail", issue_avail, ea);
      if (ev && cpl_grant) void'(q.pop_front());
      last_acc = issue_valid && ea;
      if (last_acc) begin
         e.val = drv_exp;
         e.dst = issue_dst;
         e.rob = issue_rob_idx;
         e.t   = cyc;
         q.push_back(e);
      end
      if (reset) q.delete();
   endtask

   task automatic cycle();
      if (q.size() > 0) rob_head = q[0].rob;
      else              rob_head = next_rob;
      @(negedge clk);
      check_cycle();
      if (last_acc) next_rob++;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic present(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] e, input logic [PHY_W-1:0] d);
      issue_valid   = 1'b1;
      issue_fun     = f;
      issue_rs1     = x;
      issue_rs2     = y;
      drv_exp       = e;
      issue_dst     = d;
      issue_rob_idx = next_rob;
   endtask

   task automatic issue_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] e, input logic [PHY_W-1:0] d);
      bit done;
      done = 0;
      present(f, x, y, e, d);
      for (int i = 0; i < 20 && !done; i++) begin
         cycle();
         done = last_acc;
      end
      if (!done) timeout("issue_timeout");
      issue_valid = 1'b0;
   endtask

   task automatic drain();
      issue_valid = 1'b0;
      cpl_grant   = 1'b1;
      for (int i = 0; i < 30 && q.size() > 0; i++) cycle();
      if (q.size() > 0) timeout("drain_timeout");
      cycle();
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 4))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   vec_t vt[13];

   initial begin
      logic [2:0]       rf;
      logic [31:0]      ra, rb;
      logic [ROB_W-1:0] h, victim;
      int               k;

      vt[0]  = '{3'd0, 32'd7,          32'd6,          32'd42};
      vt[1]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
      vt[2]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
      vt[3]  = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
      vt[4]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
      vt[5]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vt[6]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      vt[7]  = '{3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vt[8]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
      vt[9]  = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
      vt[10] = '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
      vt[11] = '{3'd2, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001};
      vt[12] = '{3'd1, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

      nerr = 0; nchk = 0; cyc = 0; dut_cpl = 0; dut_acc = 0;
      last_acc = 0; next_rob = '0; drv_exp = '0;
      reset = 1'b1; issue_valid = 1'b0; issue_fun = '0; issue_rs1 = '0; issue_rs2 = '0;
      issue_dst = '0; issue_rob_idx = '0; cpl_grant = 1'b0;
      rewind_valid = 1'b0; rewind_rob_idx = '0; rob_head = '0;

      @(posedge clk); #1;
      cycle();
      cycle();
      reset = 1'b0;

      // Single MUL: 7*6, dst 5, rob 3, exactly one completion pulse.
      next_rob  = 5'd3;
      cpl_grant = 1'b1;
      dut_cpl   = 0;
      issue_op(3'd0, 32'd7, 32'd6, 32'd42, 6'd5);
      drain();
      for (int i = 0; i < 3; i++) cycle();
      chk("single_pulse_count", dut_cpl, 1);

      // Arithmetic vectors, back-to-back with continuous grant.
      cpl_grant = 1'b1;
      for (int i = 0; i < 13; i++) issue_op(vt[i].fun, vt[i].a, vt[i].b, vt[i].exp_v, PHY_W'(i));
      drain();

      // Back-pressure: grant low for 6 cycles while 4 ops are offered.
      dut_acc = 0;
      k = 0;
      for (int i = 0; i < 14; i++) begin
         cpl_grant = (i >= 6);
         if (k < 4) present(vt[k].fun, vt[k].a, vt[k].b, vt[k].exp_v, PHY_W'(20 + k));
         else       issue_valid = 1'b0;
         cycle();
         if (last_acc) k++;
         if (i == 5) chk("bp_accepts_while_stalled", dut_acc, 3);
      end
      drain();
      chk("bp_total_accepts", dut_acc, 4);

      // Rewind: in flight rob 30, 31, 0 with head 30; rewind to 31 squashes two.
      next_rob  = 5'd30;
      cpl_grant = 1'b0;
      for (int i = 0; i < 3; i++) issue_op(3'd0, 32'(i + 2), 32'd3, 32'(3 * (i + 2)), PHY_W'(40 + i));
      dut_cpl        = 0;
      rewind_valid   = 1'b1;
      rewind_rob_idx = 5'd31;
      cycle();
      rewind_valid = 1'b0;
      drain();
      for (int i = 0; i < 3; i++) cycle();
      chk("rewind_completions", dut_cpl, 1);

      // Rewind of the last slot while it is requesting and granted.
      cpl_grant = 1'b0;
      victim    = next_rob;
      issue_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6'd50);
      for (int i = 0; i < 3; i++) cycle();
      dut_cpl        = 0;
      cpl_grant      = 1'b1;
      rewind_valid   = 1'b1;
      rewind_rob_idx = victim;
      cycle();
      rewind_valid = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      chk("squashed_never_broadcast", dut_cpl, 0);

      // Reset with three ops in flight.
      cpl_grant = 1'b1;
      for (int i = 0; i < 3; i++) issue_op(3'd1, 32'(i + 1), 32'hFFFF_FFFF, 32'hFFFF_FFFF, PHY_W'(60 + i));
      dut_cpl = 0;
      reset   = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      chk("no_cpl_after_reset", dut_cpl, 0);
      issue_op(3'd0, 32'd9, 32'd9, 32'd81, 6'd63);
      drain();

      // Random traffic against the reference queue.
      for (int i = 0; i < 3000; i++) begin
         if (!(issue_valid && !last_acc)) begin
            if ($urandom_range(0, 9) < 7) begin
               rf = 3'($urandom_range(0, 7));
               ra = pick_operand();
               rb = pick_operand();
               present(rf, ra, rb, ref_mul(rf, ra, rb), PHY_W'($urandom));
            end else begin
               issue_valid = 1'b0;
            end
         end
         issue_rob_idx = issue_valid ? next_rob : issue_rob_idx;
         cpl_grant     = ($urandom_range(0, 9) < 6);
         h             = (q.size() > 0) ? q[0].rob : next_rob;
         rewind_valid  = ($urandom_range(0, 19) == 0);
         rewind_rob_idx = h + ROB_W'($urandom_range(0, 3));
         reset         = ($urandom_range(0, 99) == 0);
         cycle();
      end
      reset        = 1'b0;
      rewind_valid = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
